// File: rtl/ddr_rw_arbiter.sv
// ddr_rw_arbiter: shares one mig_ctrl burst engine between a frame-writer client and a
// display-reader client. Long transfers are split into bursts of at most MAX_BURST beats.
// Bursts are interleaved round-robin, and an urgent read can take the next slot. Each
// client's data strobes are routed only while that client holds the grant.
module ddr_rw_arbiter #(
   parameter int unsigned ADDR_W    = 28,
   parameter int unsigned LEN_W     = 16,
   parameter int unsigned DATA_W    = 128,
   parameter int unsigned MAX_BURST = 64,
   parameter int unsigned ADDR_STEP = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   // write client
   input  logic              c_wr_req,
   input  logic [ADDR_W-1:0] c_wr_addr,
   input  logic [LEN_W-1:0]  c_wr_len,
   input  logic [DATA_W-1:0] c_wr_data,
   output logic              c_wr_data_valid,
   output logic              c_wr_busy,
   output logic              c_wr_done,
   // read client
   input  logic              c_rd_req,
   input  logic [ADDR_W-1:0] c_rd_addr,
   input  logic [LEN_W-1:0]  c_rd_len,
   input  logic              c_rd_urgent,
   output logic [DATA_W-1:0] c_rd_data,
   output logic              c_rd_data_valid,
   output logic              c_rd_busy,
   output logic              c_rd_done,
   // mig_ctrl write port
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_req_addr,
   output logic [LEN_W-1:0]  wr_length,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_busy,
   input  logic              wr_data_valid,
   input  logic              wr_done,
   // mig_ctrl read port
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_req_addr,
   output logic [LEN_W-1:0]  rd_length,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_busy,
   input  logic              rd_data_valid,
   input  logic              rd_done
);

   localparam logic [LEN_W-1:0]  BurstMax = LEN_W'(MAX_BURST);
   localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(ADDR_STEP);

   typedef enum logic [2:0] {
      StIdle,
      StWrIssue,
      StWrWait,
      StRdIssue,
      StRdWait
   } state_e;

   state_e state_q, state_d;
   logic   last_rd_q, last_rd_d;  // 1: read held the most recent grant

   // Burst currently presented to mig_ctrl
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [LEN_W-1:0]  wr_len_q, wr_len_d, rd_len_q, rd_len_d;

   // Per-client transfer tracking
   logic              wc_busy_q, wc_busy_d, wc_done_q, wc_done_d;
   logic [LEN_W-1:0]  wc_rem_q, wc_rem_d;
   logic [ADDR_W-1:0] wc_cur_q, wc_cur_d;
   logic              rc_busy_q, rc_busy_d, rc_done_q, rc_done_d;
   logic [LEN_W-1:0]  rc_rem_q, rc_rem_d;
   logic [ADDR_W-1:0] rc_cur_q, rc_cur_d;

   logic              wr_fin, rd_fin;    // burst completed this cycle
   logic              wc_pend, rc_pend;  // client still has beats to move
   logic              wr_grant, rd_grant;
   logic [LEN_W-1:0]  wc_chunk, rc_chunk;

   assign wc_pend  = wc_busy_q & ~wc_done_q & (wc_rem_q != '0);
   assign rc_pend  = rc_busy_q & ~rc_done_q & (rc_rem_q != '0);
   assign wc_chunk = (wc_rem_q > BurstMax) ? BurstMax : wc_rem_q;
   assign rc_chunk = (rc_rem_q > BurstMax) ? BurstMax : rc_rem_q;

   assign wr_grant = (state_q == StWrIssue) | (state_q == StWrWait);
   assign rd_grant = (state_q == StRdIssue) | (state_q == StRdWait);

   // Client-facing outputs and data routing
   assign c_wr_busy       = wc_busy_q;
   assign c_wr_done       = wc_done_q;
   assign c_rd_busy       = rc_busy_q;
   assign c_rd_done       = rc_done_q;
   assign wr_data         = c_wr_data;
   assign c_rd_data       = rd_data;
   assign c_wr_data_valid = wr_data_valid & wr_grant;
   assign c_rd_data_valid = rd_data_valid & rd_grant;
   assign wr_req_addr     = wr_addr_q;
   assign wr_length       = wr_len_q;
   assign rd_req_addr     = rd_addr_q;
   assign rd_length       = rd_len_q;

   // Arbitration and burst sequencing
   always_comb begin
      state_d   = state_q;
      last_rd_d = last_rd_q;
      wr_addr_d = wr_addr_q;
      wr_len_d  = wr_len_q;
      rd_addr_d = rd_addr_q;
      rd_len_d  = rd_len_q;
      wr_req    = 1'b0;
      rd_req    = 1'b0;
      wr_fin    = 1'b0;
      rd_fin    = 1'b0;
      case (state_q)
         StIdle: begin
            // Write wins only if read is absent, or on a non-urgent tie after a read grant
            if (wc_pend && (!rc_pend || (!c_rd_urgent && last_rd_q))) begin
               state_d   = StWrIssue;
               last_rd_d = 1'b0;
               wr_addr_d = wc_cur_q;
               wr_len_d  = wc_chunk;
            end else if (rc_pend) begin
               state_d   = StRdIssue;
               last_rd_d = 1'b1;
               rd_addr_d = rc_cur_q;
               rd_len_d  = rc_chunk;
            end
         end
         StWrIssue: begin
            // Hold off the request while mig_ctrl is still busy
            if (!wr_busy) begin
               wr_req  = 1'b1;
               state_d = StWrWait;
            end
         end
         StWrWait: begin
            if (wr_done) begin
               wr_fin  = 1'b1;
               state_d = StIdle;
            end
         end
         StRdIssue: begin
            if (!rd_busy) begin
               rd_req  = 1'b1;
               state_d = StRdWait;
            end
         end
         StRdWait: begin
            if (rd_done) begin
               rd_fin  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Write client: capture, per-burst bookkeeping, completion pulse
   always_comb begin
      wc_busy_d = wc_busy_q;
      wc_done_d = 1'b0;
      wc_rem_d  = wc_rem_q;
      wc_cur_d  = wc_cur_q;
      if (!wc_busy_q) begin
         if (c_wr_req) begin
            wc_busy_d = 1'b1;
            wc_rem_d  = c_wr_len;
            wc_cur_d  = c_wr_addr;
         end
      end else if (wc_done_q) begin
         // busy stays up through the done cycle so a same-cycle request is dropped
         wc_busy_d = 1'b0;
      end else if (wc_rem_q == '0) begin
         // zero-length request: finish without touching memory
         wc_done_d = 1'b1;
      end else if (wr_fin) begin
         wc_rem_d  = wc_rem_q - wr_len_q;
         wc_cur_d  = wc_cur_q + ADDR_W'(wr_len_q) * AddrStep;
         wc_done_d = (wc_rem_q == wr_len_q);
      end
   end

   // Read client: capture, per-burst bookkeeping, completion pulse
   always_comb begin
      rc_busy_d = rc_busy_q;
      rc_done_d = 1'b0;
      rc_rem_d  = rc_rem_q;
      rc_cur_d  = rc_cur_q;
      if (!rc_busy_q) begin
         if (c_rd_req) begin
            rc_busy_d = 1'b1;
            rc_rem_d  = c_rd_len;
            rc_cur_d  = c_rd_addr;
         end
      end else if (rc_done_q) begin
         rc_busy_d = 1'b0;
      end else if (rc_rem_q == '0) begin
         rc_done_d = 1'b1;
      end else if (rd_fin) begin
         rc_rem_d  = rc_rem_q - rd_len_q;
         rc_cur_d  = rc_cur_q + ADDR_W'(rd_len_q) * AddrStep;
         rc_done_d = (rc_rem_q == rd_len_q);
      end
   end

   // Arbiter state and issued-burst registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         last_rd_q <= 1'b1;
         wr_addr_q <= '0;
         wr_len_q  <= '0;
         rd_addr_q <= '0;
         rd_len_q  <= '0;
      end else begin
         state_q   <= state_d;
         last_rd_q <= last_rd_d;
         wr_addr_q <= wr_addr_d;
         wr_len_q  <= wr_len_d;
         rd_addr_q <= rd_addr_d;
         rd_len_q  <= rd_len_d;
      end
   end

   // Client tracking registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wc_busy_q <= 1'b0;
         wc_done_q <= 1'b0;
         wc_rem_q  <= '0;
         wc_cur_q  <= '0;
         rc_busy_q <= 1'b0;
         rc_done_q <= 1'b0;
         rc_rem_q  <= '0;
         rc_cur_q  <= '0;
      end else begin
         wc_busy_q <= wc_busy_d;
         wc_done_q <= wc_done_d;
         wc_rem_q  <= wc_rem_d;
         wc_cur_q  <= wc_cur_d;
         rc_busy_q <= rc_busy_d;
         rc_done_q <= rc_done_d;
         rc_rem_q  <= rc_rem_d;
         rc_cur_q  <= rc_cur_d;
      end
   end

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Directed bench for ddr_rw_arbiter with a small fixed-latency mig_ctrl model.
module tb_ddr_rw_arbiter;

   localparam int ADDR_W = 28;
   localparam int LEN_W  = 16;
   localparam int DATA_W = 128;
   localparam int LAT    = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              c_wr_req, c_rd_req, c_rd_urgent;
   logic [ADDR_W-1:0] c_wr_addr, c_rd_addr;
   logic [LEN_W-1:0]  c_wr_len, c_rd_len;
   logic [DATA_W-1:0] c_wr_data, c_rd_data, wr_data, rd_data;
   logic              c_wr_data_valid, c_wr_busy, c_wr_done;
   logic              c_rd_data_valid, c_rd_busy, c_rd_done;
   logic              wr_req, rd_req;
   logic [ADDR_W-1:0] wr_req_addr, rd_req_addr;
   logic [LEN_W-1:0]  wr_length, rd_length;
   logic              wr_busy, wr_data_valid, wr_done, rd_busy, rd_data_valid, rd_done;

   logic hold_wr_busy, stray_rd_dv, stray_wr_done;
   logic m_wr_busy, m_wr_dv, m_wr_done, m_rd_busy, m_rd_dv, m_rd_done;
   int   wcnt, rcnt;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int viol = 0;
   int wdone_n = 0, rdone_n = 0, wdone_cyc = 0, rdone_cyc = 0;
   int log_kind[$], log_len[$], log_addr[$], log_cyc[$];
   int mwd_cyc[$], mrd_cyc[$];

   always #5 clk = ~clk;

   assign wr_busy       = m_wr_busy | hold_wr_busy;
   assign wr_data_valid = m_wr_dv;
   assign wr_done       = m_wr_done | stray_wr_done;
   assign rd_busy       = m_rd_busy;
   assign rd_data_valid = m_rd_dv | stray_rd_dv;
   assign rd_done       = m_rd_done;

   ddr_rw_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .c_wr_req(c_wr_req), .c_wr_addr(c_wr_addr), .c_wr_len(c_wr_len),
      .c_wr_data(c_wr_data), .c_wr_data_valid(c_wr_data_valid),
      .c_wr_busy(c_wr_busy), .c_wr_done(c_wr_done),
      .c_rd_req(c_rd_req), .c_rd_addr(c_rd_addr), .c_rd_len(c_rd_len),
      .c_rd_urgent(c_rd_urgent), .c_rd_data(c_rd_data),
      .c_rd_data_valid(c_rd_data_valid), .c_rd_busy(c_rd_busy), .c_rd_done(c_rd_done),
      .wr_req(wr_req), .wr_req_addr(wr_req_addr), .wr_length(wr_length),
      .wr_data(wr_data), .wr_busy(wr_busy), .wr_data_valid(wr_data_valid),
      .wr_done(wr_done),
      .rd_req(rd_req), .rd_req_addr(rd_req_addr), .rd_length(rd_length),
      .rd_data(rd_data), .rd_busy(rd_busy), .rd_data_valid(rd_data_valid),
      .rd_done(rd_done)
   );

   // mig_ctrl model: accept a request, stay busy LAT cycles with data strobes, then pulse done
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wr_busy <= 1'b0; m_wr_dv <= 1'b0; m_wr_done <= 1'b0; wcnt <= 0;
         m_rd_busy <= 1'b0; m_rd_dv <= 1'b0; m_rd_done <= 1'b0; rcnt <= 0;
      end else begin
         m_wr_done <= 1'b0;
         m_rd_done <= 1'b0;
         if (wcnt != 0) begin
            wcnt <= wcnt - 1;
            if (wcnt == 1) begin
               m_wr_done <= 1'b1; m_wr_busy <= 1'b0; m_wr_dv <= 1'b0;
            end
         end else if (wr_req) begin
            wcnt <= LAT; m_wr_busy <= 1'b1; m_wr_dv <= 1'b1;
         end
         if (rcnt != 0) begin
            rcnt <= rcnt - 1;
            if (rcnt == 1) begin
               m_rd_done <= 1'b1; m_rd_busy <= 1'b0; m_rd_dv <= 1'b0;
            end
         end else if (rd_req) begin
            rcnt <= LAT; m_rd_busy <= 1'b1; m_rd_dv <= 1'b1;
         end
      end
   end

   // Monitor: cycle count, issued-burst log, done timestamps, protocol and routing violations
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (wr_req) begin
         log_kind.push_back(0); log_len.push_back(int'(wr_length));
         log_addr.push_back(int'(wr_req_addr)); log_cyc.push_back(cyc);
      end
      if (rd_req) begin
         log_kind.push_back(1); log_len.push_back(int'(rd_length));
         log_addr.push_back(int'(rd_req_addr)); log_cyc.push_back(cyc);
      end
      if (m_wr_done) mwd_cyc.push_back(cyc);
      if (m_rd_done) mrd_cyc.push_back(cyc);
      if (c_wr_done) begin wdone_n <= wdone_n + 1; wdone_cyc <= cyc; end
      if (c_rd_done) begin rdone_n <= rdone_n + 1; rdone_cyc <= cyc; end
      if ((wr_req && rd_req) || (c_wr_data_valid !== m_wr_dv) || (c_rd_data_valid !== m_rd_dv))
         viol <= viol + 1;
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      c_wr_req = 0; c_rd_req = 0; c_rd_urgent = 0;
      hold_wr_busy = 0; stray_rd_dv = 0; stray_wr_done = 0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic req_wr(input int addr, input int len);
      c_wr_req = 1'b1; c_wr_addr = ADDR_W'(addr); c_wr_len = LEN_W'(len);
      tick(1);
      c_wr_req = 1'b0;
   endtask

   task automatic req_rd(input int addr, input int len);
      c_rd_req = 1'b1; c_rd_addr = ADDR_W'(addr); c_rd_len = LEN_W'(len);
      tick(1);
      c_rd_req = 1'b0;
   endtask

   task automatic wait_dones(input string tag, input int wt, input int rt);
      int b = 0;
      while ((wdone_n < wt || rdone_n < rt) && b < 2000) begin
         tick(1);
         b++;
      end
      check_eq({tag, "_completed"}, (wdone_n >= wt) && (rdone_n >= rt), 1);
   endtask

   task automatic wait_log(input int target);
      int b = 0;
      while (log_kind.size() < target && b < 200) begin
         tick(1);
         b++;
      end
      check_eq("burst_issued", log_kind.size() >= target, 1);
   endtask

   task automatic check_burst(input string tag, input int idx, input int kind, input int len,
                              input int addr);
      check_eq({tag, "_kind"}, log_kind[idx], kind);
      check_eq({tag, "_len"}, log_len[idx], len);
      check_eq({tag, "_addr"}, log_addr[idx], addr);
   endtask

   initial begin
      int b, wb, rb, md, t0;
      c_wr_req = 0; c_rd_req = 0; c_rd_urgent = 0;
      c_wr_addr = '0; c_rd_addr = '0; c_wr_len = '0; c_rd_len = '0;
      c_wr_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      rd_data   = 128'ha5a5_0000_5a5a_1111_c3c3_2222_3c3c_3333;
      hold_wr_busy = 0; stray_rd_dv = 0; stray_wr_done = 0;
      #1 rst_n = 1'b0;
      tick(1);
      check_eq("rst_wr_busy", c_wr_busy, 0);
      check_eq("rst_rd_busy", c_rd_busy, 0);
      check_eq("rst_reqs", {wr_req, rd_req, c_wr_done, c_rd_done}, 0);
      check_eq("rst_wr_len_addr", {wr_length, wr_req_addr}, 0);
      rst_n = 1'b1;
      tick(1);
      check_eq("wr_data_route", wr_data, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
      check_eq("rd_data_route", c_rd_data, 128'ha5a5_0000_5a5a_1111_c3c3_2222_3c3c_3333);

      // Write only: 150 beats -> 64, 64, 22
      do_reset();
      b = log_kind.size(); wb = wdone_n; md = mwd_cyc.size(); t0 = cyc;
      req_wr('h100, 150);
      check_eq("wo_busy_next", c_wr_busy, 1);
      wait_dones("wo", wb + 1, 0);
      tick(5);
      check_eq("wo_bursts", log_kind.size() - b, 3);
      check_burst("wo_b0", b, 0, 64, 'h100);
      check_burst("wo_b1", b + 1, 0, 64, 'h300);
      check_burst("wo_b2", b + 2, 0, 22, 'h500);
      check_eq("wo_req_latency", log_cyc[b] - t0, 2);
      check_eq("wo_done_latency", wdone_cyc - mwd_cyc[md + 2], 1);
      check_eq("wo_done_count", wdone_n - wb, 1);
      check_eq("wo_busy_clear", c_wr_busy, 0);

      // Round-robin: simultaneous 128-beat write and read
      do_reset();
      b = log_kind.size(); wb = wdone_n; rb = rdone_n; md = mwd_cyc.size();
      c_wr_addr = ADDR_W'('h1000); c_wr_len = LEN_W'(128);
      c_rd_addr = ADDR_W'('h8000); c_rd_len = LEN_W'(128);
      c_wr_req = 1; c_rd_req = 1;
      tick(1);
      c_wr_req = 0; c_rd_req = 0;
      wait_log(b + 1);
      tick(2);
      stray_rd_dv = 1'b1;
      #1 check_eq("rr_rd_valid_gated", c_rd_data_valid, 0);
      stray_rd_dv = 1'b0;
      wait_dones("rr", wb + 1, rb + 1);
      check_eq("rr_bursts", log_kind.size() - b, 4);
      check_burst("rr_b0", b, 0, 64, 'h1000);
      check_burst("rr_b1", b + 1, 1, 64, 'h8000);
      check_burst("rr_b2", b + 2, 0, 64, 'h1200);
      check_burst("rr_b3", b + 3, 1, 64, 'h8200);
      check_eq("rr_next_issue_gap", log_cyc[b + 1] - mwd_cyc[md], 2);

      // Urgent tie: read granted twice in a row ahead of round-robin
      do_reset();
      b = log_kind.size(); wb = wdone_n; rb = rdone_n;
      c_rd_urgent = 1;
      c_wr_addr = '0; c_wr_len = LEN_W'(256);
      c_rd_addr = ADDR_W'('h4000); c_rd_len = LEN_W'(128);
      c_wr_req = 1; c_rd_req = 1;
      tick(1);
      c_wr_req = 0; c_rd_req = 0;
      wait_dones("urg_tie", wb + 1, rb + 1);
      c_rd_urgent = 0;
      check_eq("urg_tie_bursts", log_kind.size() - b, 6);
      check_burst("urg_tie_b0", b, 1, 64, 'h4000);
      check_burst("urg_tie_b1", b + 1, 1, 64, 'h4200);
      check_burst("urg_tie_b2", b + 2, 0, 64, 'h0);
      check_burst("urg_tie_b5", b + 5, 0, 64, 'h600);

      // Urgent read arriving during a long write
      do_reset();
      b = log_kind.size(); wb = wdone_n; rb = rdone_n; md = mwd_cyc.size();
      req_wr(0, 256);
      wait_log(b + 1);
      tick(1);
      c_rd_urgent = 1;
      req_rd('h6000, 64);
      wait_dones("urg_mid", wb + 1, rb + 1);
      c_rd_urgent = 0;
      check_eq("urg_mid_bursts", log_kind.size() - b, 5);
      check_burst("urg_mid_b1", b + 1, 1, 64, 'h6000);
      check_eq("urg_mid_issue_gap", log_cyc[b + 1] - mwd_cyc[md], 2);

      // Zero-length read, ignored re-requests while busy and on the done cycle
      do_reset();
      b = log_kind.size(); wb = wdone_n; rb = rdone_n; t0 = cyc;
      req_rd('h700, 0);
      wait_dones("zl", 0, rb + 1);
      check_eq("zl_done_latency", rdone_cyc - t0, 2);
      check_eq("zl_no_rd_req", log_kind.size() - b, 0);
      req_wr('h2000, 64);
      tick(2);
      req_wr('h9000, 100);
      begin
         int k = 0;
         while (!c_wr_done && k < 200) begin tick(1); k++; end
         check_eq("bz_done_seen", c_wr_done, 1);
      end
      check_eq("bz_busy_in_done_cycle", c_wr_busy, 1);
      req_wr('ha000, 8);
      tick(30);
      check_eq("bz_bursts", log_kind.size() - b, 1);
      check_burst("bz_b0", b, 0, 64, 'h2000);
      check_eq("bz_done_count", wdone_n - wb, 1);
      check_eq("bz_busy_clear", c_wr_busy, 0);

      // Stray done while idle, then port busy holds off the request
      do_reset();
      b = log_kind.size(); wb = wdone_n;
      stray_wr_done = 1;
      tick(1);
      stray_wr_done = 0;
      tick(3);
      check_eq("stray_done_ignored", {c_wr_busy, 16'(wdone_n - wb)}, 0);
      hold_wr_busy = 1;
      req_wr('h40, 10);
      tick(5);
      check_eq("pb_no_req", {wr_req, 16'(log_kind.size() - b)}, 0);
      check_eq("pb_len_in_issue", wr_length, 10);
      hold_wr_busy = 0;
      t0 = cyc;
      #1 check_eq("pb_req_on_release", wr_req, 1);
      wait_dones("pb", wb + 1, 0);
      check_eq("pb_bursts", log_kind.size() - b, 1);
      check_eq("pb_req_cycle", log_cyc[b] - t0, 0);
      check_eq("pb_len", log_len[b], 10);

      // Reset during a read burst
      do_reset();
      b = log_kind.size(); rb = rdone_n;
      req_rd('h2000, 64);
      wait_log(b + 1);
      tick(2);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", {c_rd_busy, rd_req, c_rd_data_valid}, 0);
      check_eq("mid_rst_len_addr", {rd_length, rd_req_addr}, 0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      req_rd('h3000, 32);
      wait_dones("post_rst", 0, rb + 1);
      check_eq("post_rst_bursts", log_kind.size() - b, 2);
      check_burst("post_rst_b", b + 1, 1, 32, 'h3000);
      check_eq("post_rst_done_count", rdone_n - rb, 1);

      check_eq("protocol_routing", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
